// File: rtl/bcd_to_exc3_serial_pkg.sv
// ============================================================================
// Module      : bcd_to_exc3_serial_pkg
// Description : Shared state encodings and digit constants for the
//               digit-serial BCD to excess-3 encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_to_exc3_serial_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Excess-3 offset added to every digit
    localparam logic [3:0] EXC3_OFFSET = 4'd3;

    // Largest legal BCD digit value
    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage : bcd_to_exc3_serial_pkg

`default_nettype wire

// File: rtl/bcd_digit_to_exc3.sv
// ============================================================================
// Module      : bcd_digit_to_exc3
// Description : Combinational single-digit BCD to excess-3 converter with an
//               invalid-digit flag. Non-BCD inputs still wrap modulo 16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_to_exc3
    import bcd_to_exc3_serial_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_exc3,
    output logic       o_invalid
);

    // 4-bit wraparound add and range check
    always_comb begin
        o_exc3    = i_digit + EXC3_OFFSET;
        o_invalid = (i_digit > BCD_MAX);
    end

endmodule : bcd_digit_to_exc3

`default_nettype wire

// File: rtl/bcd_to_exc3_serial.sv
// ============================================================================
// Module      : bcd_to_exc3_serial
// Description : Digit-serial packed-BCD to excess-3 encoder with valid/ready
//               handshakes. One digit is converted per clock through a single
//               shared digit converter selected by the digit counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_exc3_serial
    import bcd_to_exc3_serial_pkg::*;
#(
    parameter int DIGITS = 4
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_bcd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_exc3,
    output logic                out_err,
    output logic                busy
);

    localparam int c_W  = 4 * DIGITS;
    localparam int c_CW = $clog2(DIGITS + 1);

    localparam logic [c_CW-1:0] c_LAST_CNT = c_CW'(DIGITS - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [c_W-1:0]  r_word;
    logic [c_CW-1:0] r_cnt;
    logic [c_W-1:0]  r_exc3;
    logic            r_err;

    logic [c_CW+1:0] w_shamt;
    logic [c_W-1:0]  w_shifted;
    logic [3:0]      w_digit;
    logic [3:0]      w_exc3_digit;
    logic            w_invalid;
    logic [c_W-1:0]  w_mask;
    logic [c_W-1:0]  w_insert;

    // Select the current digit and build the write mask for its slot
    always_comb begin
        w_shamt   = {r_cnt, 2'b00};
        w_shifted = r_word >> w_shamt;
        w_digit   = w_shifted[3:0];
        w_mask    = c_W'(4'hF) << w_shamt;
        w_insert  = c_W'(w_exc3_digit) << w_shamt;
    end

    bcd_digit_to_exc3 u_digit (
        .i_digit   (w_digit),
        .o_exc3    (w_exc3_digit),
        .o_invalid (w_invalid)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)            w_next_state = ST_CONV;
            ST_CONV: if (r_cnt == c_LAST_CNT) w_next_state = ST_DONE;
            ST_DONE: if (out_ready)           w_next_state = ST_IDLE;
            default:                          w_next_state = ST_IDLE;
        endcase
    end

    // Handshake and status outputs; in_ready is held low during reset
    always_comb begin
        in_ready  = (r_state == ST_IDLE) && rst_n;
        out_valid = (r_state == ST_DONE);
        busy      = (r_state == ST_CONV) || (r_state == ST_DONE);
    end

    // Word capture, per-digit conversion and error accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_cnt  <= '0;
            r_exc3 <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_word <= in_bcd;
                        r_cnt  <= '0;
                        r_err  <= 1'b0;
                    end
                end
                ST_CONV: begin
                    r_exc3 <= (r_exc3 & ~w_mask) | w_insert;
                    r_err  <= r_err | w_invalid;
                    r_cnt  <= r_cnt + c_CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign out_exc3 = r_exc3;
    assign out_err  = r_err;

endmodule : bcd_to_exc3_serial

`default_nettype wire

// File: tb/tb_bcd_to_exc3_serial.sv
// ============================================================================
// Module      : tb_bcd_to_exc3_serial
// Description : Directed self-checking bench for bcd_to_exc3_serial, covering
//               a 4-digit build and a 1-digit build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_exc3_serial;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_exc3;
    logic        out_err;
    logic        busy;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [3:0]  s_in_bcd;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [3:0]  s_out_exc3;
    logic        s_out_err;
    logic        s_busy;

    int n_checks = 0;
    int n_errors = 0;

    bcd_to_exc3_serial #(.DIGITS(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_exc3  (out_exc3),
        .out_err   (out_err),
        .busy      (busy)
    );

    bcd_to_exc3_serial #(.DIGITS(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_bcd    (s_in_bcd),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_exc3  (s_out_exc3),
        .out_err   (s_out_err),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture one word on the 4-digit build, check latency and result
    task automatic run_word(input string tag, input logic [15:0] bcd,
                            input logic [15:0] exp, input logic exp_err);
        int n;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_bcd   = bcd;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 20);
        check({tag, "_latency"}, n, 32'd4);
        check({tag, "_exc3"}, {16'd0, out_exc3}, {16'd0, exp});
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_bcd      = '0;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_bcd    = '0;
        s_out_ready = 1'b1;
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_exc3", {16'd0, out_exc3}, 32'd0);
        check("rst_err", {31'd0, out_err}, 32'd0);
        #3 rst_n = 1'b1;
        tick();

        // Basic word, out_valid high exactly one cycle
        run_word("w1234", 16'h1234, 16'h4567, 1'b0);
        tick();
        check("w1234_valid_drop", {31'd0, out_valid}, 32'd0);
        check("w1234_idle_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back with in_valid held: captures 6 cycles apart
        in_bcd   = 16'h0000;
        in_valid = 1'b1;
        tick();
        check("b2b_cap0", {31'd0, busy}, 32'd1);
        in_bcd = 16'h9999;
        repeat (4) tick();
        check("b2b_valid0", {31'd0, out_valid}, 32'd1);
        check("b2b_exc3_0", {16'd0, out_exc3}, 32'h3333);
        check("b2b_err0", {31'd0, out_err}, 32'd0);
        tick();
        check("b2b_idle", {31'd0, in_ready}, 32'd1);
        tick();
        check("b2b_cap1", {31'd0, busy}, 32'd1);
        check("b2b_cap1_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        repeat (4) tick();
        check("b2b_valid1", {31'd0, out_valid}, 32'd1);
        check("b2b_exc3_1", {16'd0, out_exc3}, 32'hCCCC);
        check("b2b_err1", {31'd0, out_err}, 32'd0);
        tick();

        // Invalid digit, then error clears on the next word
        run_word("w12A4", 16'h12A4, 16'h45D7, 1'b1);
        tick();
        run_word("w0101", 16'h0101, 16'h3434, 1'b0);
        tick();

        // Backpressure: result held, in_valid pulses ignored
        out_ready = 1'b0;
        run_word("bp", 16'h5678, 16'h89AB, 1'b0);
        in_bcd = 16'h1111;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            tick();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_exc3", {16'd0, out_exc3}, 32'h89AB);
            check("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_busy", {31'd0, busy}, 32'd0);
        check("bp_keep_exc3", {16'd0, out_exc3}, 32'h89AB);

        // Reset mid-conversion at cnt=2
        in_bcd   = 16'h4444;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_ready", {31'd0, in_ready}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_exc3", {16'd0, out_exc3}, 32'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        run_word("w0987", 16'h0987, 16'h3CBA, 1'b0);
        tick();

        // Single-digit build
        s_in_bcd   = 4'h5;
        s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        check("d1_cap_busy", {31'd0, s_busy}, 32'd1);
        check("d1_cap_valid", {31'd0, s_out_valid}, 32'd0);
        tick();
        check("d1_5_valid", {31'd0, s_out_valid}, 32'd1);
        check("d1_5_exc3", {28'd0, s_out_exc3}, 32'h8);
        check("d1_5_err", {31'd0, s_out_err}, 32'd0);
        tick();
        check("d1_idle", {31'd0, s_in_ready}, 32'd1);
        s_in_bcd   = 4'hF;
        s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        tick();
        check("d1_F_valid", {31'd0, s_out_valid}, 32'd1);
        check("d1_F_exc3", {28'd0, s_out_exc3}, 32'h2);
        check("d1_F_err", {31'd0, s_out_err}, 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bcd_to_exc3_serial

`default_nettype wire
